// File: rtl/shared_pattern_ram_if.sv
// rtl/shared_pattern_ram_if.sv - Wishbone responder port bundle for shared_pattern_ram
interface shared_pattern_ram_if #(
    parameter int ADR_W = 32
);
    logic             stb_i;
    logic             cyc_i;
    logic             we_i;
    logic [3:0]       sel_i;
    logic [31:0]      dat_i;
    logic [ADR_W-1:0] adr_i;
    logic             ack_o;
    logic [31:0]      dat_o;

    modport master (
        output stb_i, cyc_i, we_i, sel_i, dat_i, adr_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  stb_i, cyc_i, we_i, sel_i, dat_i, adr_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/shared_pattern_ram.sv
// rtl/shared_pattern_ram.sv - 256x32 pattern RAM shared by Caravel and RAMBus Wishbone ports (optional SHARED_RAM_ROUND_ROBIN_EN)
module shared_pattern_ram #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_1000,
    parameter int          DEPTH_LOG2   = 8
) (
    input  logic                  caravel_wb_clk_i,
    input  logic                  caravel_wb_rst_i,
    input  logic                  rambus_wb_clk_i,
    input  logic                  rambus_wb_rst_i,
    shared_pattern_ram_if.slave   caravel_wb,
    shared_pattern_ram_if.slave   rambus_wb
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic clk;
    logic rst;
    assign clk = caravel_wb_clk_i;
    assign rst = caravel_wb_rst_i | rambus_wb_rst_i;

    // RAMBus clock is the same net as the Caravel clock; byte offset bits carry no information
    logic unused_ok;
    assign unused_ok = &{1'b0, rambus_wb_clk_i, caravel_wb.adr_i[1:0]};

    logic [31:0] mem [0:DEPTH-1];

    logic        c_ack, r_ack;
    logic [31:0] c_dat, r_dat;
    logic        c_req, r_req;
    logic        gnt_c, gnt_r;

    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  acc_we;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_dat;

    // The "!ack" term stops a master that still holds stb in its ack cycle from being re-accepted
    assign c_req = caravel_wb.stb_i & caravel_wb.cyc_i & ~c_ack
                 & (caravel_wb.adr_i[31:10] == BASE_ADDRESS[31:10]);
    assign r_req = rambus_wb.stb_i & rambus_wb.cyc_i & ~r_ack;

`ifdef SHARED_RAM_ROUND_ROBIN_EN
    logic rr_rambus_first;

    // Remember who won the last contested cycle so the other port wins the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_rambus_first <= 1'b0;
        end else if (c_req && r_req) begin
            rr_rambus_first <= gnt_c;
        end
    end

    // Grant: sole requester wins, contested cycles alternate
    always_comb begin
        gnt_c = 1'b0;
        gnt_r = 1'b0;
        if (!rst) begin
            if (c_req && r_req) begin
                gnt_r = rr_rambus_first;
                gnt_c = ~rr_rambus_first;
            end else begin
                gnt_c = c_req;
                gnt_r = r_req;
            end
        end
    end
`else
    // Grant: sole requester wins, Caravel wins contested cycles
    always_comb begin
        gnt_c = 1'b0;
        gnt_r = 1'b0;
        if (!rst) begin
            gnt_c = c_req;
            gnt_r = r_req & ~c_req;
        end
    end
`endif

    // Steer the granted port onto the single array port
    always_comb begin
        acc_idx = rambus_wb.adr_i[DEPTH_LOG2-1:0];
        acc_we  = rambus_wb.we_i;
        acc_sel = rambus_wb.sel_i;
        acc_dat = rambus_wb.dat_i;
        if (gnt_c) begin
            acc_idx = caravel_wb.adr_i[DEPTH_LOG2+1:2];
            acc_we  = caravel_wb.we_i;
            acc_sel = caravel_wb.sel_i;
            acc_dat = caravel_wb.dat_i;
        end
    end

    // Byte-lane write into the array; contents survive reset
    always_ff @(posedge clk) begin
        if ((gnt_c || gnt_r) && acc_we) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_sel[k]) begin
                    mem[acc_idx][8*k +: 8] <= acc_dat[8*k +: 8];
                end
            end
        end
    end

    // Registered acks and read data; dat_o only reloads on a read grant to that port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_ack <= 1'b0;
            r_ack <= 1'b0;
            c_dat <= 32'h0;
            r_dat <= 32'h0;
        end else begin
            c_ack <= gnt_c;
            r_ack <= gnt_r;
            if (gnt_c && !acc_we) begin
                c_dat <= mem[acc_idx];
            end
            if (gnt_r && !acc_we) begin
                r_dat <= mem[acc_idx];
            end
        end
    end

    assign caravel_wb.ack_o = c_ack;
    assign caravel_wb.dat_o = c_dat;
    assign rambus_wb.ack_o  = r_ack;
    assign rambus_wb.dat_o  = r_dat;
endmodule
